// File: rtl/riscv_definitions.sv
// Shared types and constants for the memory arbiter: FSM states, access
// size encodings, grant identifiers and the default bus timeout.
package riscv_definitions;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        INST_WAIT = 2'b01,
        DATA_WAIT = 2'b10,
        DONE      = 2'b11
    } arb_state_e;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables and store replication for the
// access being granted, and load extraction for the access in flight.
module mem_align
    import riscv_definitions::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wr_data,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b0000;
        lane_data  = wr_data;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << off;
                lane_data = {4{wr_data[7:0]}};
            end
            SIZE_H: begin
                be         = 4'b0011 << off;
                lane_data  = {2{wr_data[15:0]}};
                misaligned = off[0];
            end
            SIZE_W: begin
                be         = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Zero-extension only; the core applies sign extension itself.
    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_size)
            SIZE_B:  load_data = {24'h0, shifted[7:0]};
            SIZE_H:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto a single memory
// port with one outstanding transaction, timeout and misalignment detection.
module mem_arbiter
    import riscv_definitions::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              inst_rd_en,
    input  logic [31:0]       inst_addr,
    output logic              inst_ready,
    output logic [31:0]       inst_data,
    input  logic              data_rd_en_ma,
    input  logic              data_wr_en_ma,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wr,
    input  logic [1:0]        data_rd_wr_ctrl,
    output logic              data_ready,
    output logic [31:0]       data_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              bus_err,
    output logic              misalign_err,
    output arb_state_e        state_dbg
);

    // Handshake: a requester holds its enable and address until its ready
    // pulse; mem_req and its fields stay stable until mem_ack is sampled high.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state, state_n;
    grant_e            last_grant, last_grant_n;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [3:0]        mem_be_n;
    logic [31:0]       mem_wdata_n;
    logic [1:0]        acc_off, acc_off_n, acc_size, acc_size_n;
    logic              inst_ready_n, data_ready_n, bus_err_n, misalign_err_n;
    logic [31:0]       inst_data_n, data_rd_n;

    logic              inst_pend, data_pend, grant_inst, grant_data, sel_we;
    logic [31:0]       sel_addr;
    logic [1:0]        sel_size;
    logic [3:0]        be;
    logic [31:0]       lane_data, load_data;
    logic              misaligned;

    assign inst_pend  = inst_rd_en;
    assign data_pend  = data_rd_en_ma | data_wr_en_ma;
    assign grant_data = data_pend && (!inst_pend || last_grant == GRANT_INST);
    assign grant_inst = inst_pend && !grant_data;
    assign sel_addr   = grant_data ? data_addr : inst_addr;
    assign sel_size   = grant_data ? data_rd_wr_ctrl : SIZE_W;
    assign sel_we     = grant_data && data_wr_en_ma;
    assign state_dbg  = state;

    mem_align u_align (
        .off       (sel_addr[1:0]),
        .size      (sel_size),
        .wr_data   (data_wr),
        .be        (be),
        .lane_data (lane_data),
        .misaligned(misaligned),
        .ld_off    (acc_off),
        .ld_size   (acc_size),
        .rdata     (mem_rdata),
        .load_data (load_data)
    );

    always_comb begin
        state_n        = state;
        last_grant_n   = last_grant;
        wait_cnt_n     = wait_cnt;
        mem_req_n      = mem_req;
        mem_we_n       = mem_we;
        mem_addr_n     = mem_addr;
        mem_be_n       = mem_be;
        mem_wdata_n    = mem_wdata;
        acc_off_n      = acc_off;
        acc_size_n     = acc_size;
        inst_ready_n   = 1'b0;
        data_ready_n   = 1'b0;
        bus_err_n      = 1'b0;
        misalign_err_n = 1'b0;
        inst_data_n    = inst_data;
        data_rd_n      = data_rd;
        case (state)
            IDLE: begin
                if (grant_inst || grant_data) begin
                    last_grant_n = grant_data ? GRANT_DATA : GRANT_INST;
                    acc_off_n    = sel_addr[1:0];
                    acc_size_n   = sel_size;
                    if (misaligned) begin
                        // Rejected without touching memory; answer next cycle.
                        state_n        = DONE;
                        misalign_err_n = 1'b1;
                        if (grant_data) begin
                            data_ready_n = 1'b1;
                            data_rd_n    = '0;
                        end else begin
                            inst_ready_n = 1'b1;
                            inst_data_n  = '0;
                        end
                    end else begin
                        state_n     = grant_data ? DATA_WAIT : INST_WAIT;
                        mem_req_n   = 1'b1;
                        mem_we_n    = sel_we;
                        mem_addr_n  = ADDR_W'({sel_addr[31:2], 2'b00});
                        mem_be_n    = be;
                        mem_wdata_n = lane_data;
                        wait_cnt_n  = '0;
                    end
                end
            end
            INST_WAIT, DATA_WAIT: begin
                if (mem_ack) begin
                    state_n   = DONE;
                    mem_req_n = 1'b0;
                    if (state == DATA_WAIT) begin
                        data_ready_n = 1'b1;
                        data_rd_n    = load_data;
                    end else begin
                        inst_ready_n = 1'b1;
                        inst_data_n  = load_data;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n   = DONE;
                    mem_req_n = 1'b0;
                    bus_err_n = 1'b1;
                    if (state == DATA_WAIT) begin
                        data_ready_n = 1'b1;
                        data_rd_n    = '0;
                    end else begin
                        inst_ready_n = 1'b1;
                        inst_data_n  = '0;
                    end
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                state_n    = IDLE;
                wait_cnt_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= GRANT_INST;
            wait_cnt     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            acc_off      <= '0;
            acc_size     <= SIZE_W;
            inst_ready   <= 1'b0;
            data_ready   <= 1'b0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            inst_data    <= '0;
            data_rd      <= '0;
        end else if (clk_en) begin
            state        <= state_n;
            last_grant   <= last_grant_n;
            wait_cnt     <= wait_cnt_n;
            mem_req      <= mem_req_n;
            mem_we       <= mem_we_n;
            mem_addr     <= mem_addr_n;
            mem_be       <= mem_be_n;
            mem_wdata    <= mem_wdata_n;
            acc_off      <= acc_off_n;
            acc_size     <= acc_size_n;
            inst_ready   <= inst_ready_n;
            data_ready   <= data_ready_n;
            bus_err      <= bus_err_n;
            misalign_err <= misalign_err_n;
            inst_data    <= inst_data_n;
            data_rd      <= data_rd_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: arbitration, lane handling, errors,
// clock-enable freeze and reset behaviour.
module tb_mem_arbiter;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    logic        rst_n, clk_en;
    logic        inst_rd_en;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        data_rd_en_ma, data_wr_en_ma;
    logic [31:0] data_addr, data_wr;
    logic [1:0]  data_rd_wr_ctrl;
    logic        data_ready;
    logic [31:0] data_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        bus_err, misalign_err;
    arb_state_e  state_dbg;

    logic        ack_mode, ack_force;
    logic [31:0] rdata_val;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    logic [31:0] ld_addr[5] = '{32'h22, 32'h21, 32'h23, 32'h20, 32'h24};
    logic [1:0]  ld_size[5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
    logic [3:0]  ld_be[5]   = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111};
    logic [31:0] ld_exp[5]  = '{32'h0000BEEF, 32'h00000012, 32'h000000BE,
                                32'h00001234, 32'hBEEF1234};

    mem_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .inst_rd_en(inst_rd_en), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .inst_data(inst_data),
        .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
        .data_addr(data_addr), .data_wr(data_wr),
        .data_rd_wr_ctrl(data_rd_wr_ctrl), .data_ready(data_ready),
        .data_rd(data_rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err),
        .misalign_err(misalign_err), .state_dbg(state_dbg)
    );

    // Clock and memory responder
    always #5 clk = ~clk;
    assign mem_ack   = ack_mode ? mem_req : ack_force;
    assign mem_rdata = rdata_val;

    always @(posedge clk) begin
        if (rst_n && clk_en && mem_req && mem_ack) obs_q.push_back(mem_addr);
    end

    // Driver tasks
    task step;
        @(posedge clk);
        #1;
    endtask

    task idle_inputs;
        inst_rd_en      = 1'b0;
        data_rd_en_ma   = 1'b0;
        data_wr_en_ma   = 1'b0;
    endtask

    task wait_ready(input bit want_data, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (want_data ? data_ready : inst_ready) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task test_reset;
        rst_n = 1'b0; clk_en = 1'b1; ack_mode = 1'b0; ack_force = 1'b0;
        rdata_val = '0; inst_addr = '0; data_addr = '0; data_wr = '0;
        data_rd_wr_ctrl = 2'b10;
        idle_inputs();
        step(); step();
        total++;
        if ({mem_req, mem_we, inst_ready, data_ready, bus_err, misalign_err} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000",
                {mem_req, mem_we, inst_ready, data_ready, bus_err, misalign_err});
        end
        total++;
        if ({mem_addr, mem_be, mem_wdata, inst_data, data_rd} !== '0) begin
            bad++; $display("FAIL reset_data: addr %h be %b wdata %h inst %h data %h want 0",
                mem_addr, mem_be, mem_wdata, inst_data, data_rd);
        end
        total++;
        if (state_dbg !== IDLE) begin
            bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        end
        rst_n = 1'b1;
        step();
    endtask

    task test_round_robin;
        bit seen;
        obs_q.delete();
        ack_mode = 1'b1; rdata_val = 32'h1111_2222;
        for (int r = 0; r < 2; r++) begin
            inst_rd_en = 1'b1; inst_addr = 32'h104;
            data_rd_en_ma = 1'b1; data_addr = 32'h20; data_rd_wr_ctrl = 2'b10;
            wait_ready(1'b1, seen);
            total++;
            if (!seen || data_rd !== 32'h1111_2222) begin
                bad++; $display("FAIL rr_data_first: seen %0b data %h want 1 11112222", seen, data_rd);
            end
            data_rd_en_ma = 1'b0;
            wait_ready(1'b0, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL rr_inst_second: seen 0 want 1"); end
            inst_rd_en = 1'b0;
            step();
        end
        exp_q = '{32'h20, 32'h104, 32'h20, 32'h104};
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rr_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        // A rejected data grant still counts as the last grant.
        data_rd_en_ma = 1'b1; data_addr = 32'h20; data_rd_wr_ctrl = 2'b11;
        step();
        total++;
        if ({data_ready, misalign_err, mem_req} !== 3'b110) begin
            bad++; $display("FAIL rr_illegal_size: got %b want 110", {data_ready, misalign_err, mem_req});
        end
        data_rd_en_ma = 1'b0;
        step();
        obs_q.delete();
        inst_rd_en = 1'b1; data_rd_en_ma = 1'b1; data_rd_wr_ctrl = 2'b10;
        wait_ready(1'b0, seen);
        inst_rd_en = 1'b0;
        wait_ready(1'b1, seen);
        data_rd_en_ma = 1'b0;
        step();
        total++;
        if (obs_q.size() != 2 || obs_q[0] !== 32'h104) begin
            bad++; $display("FAIL rr_after_error: count %0d first %h want 2 00000104",
                obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx);
        end
    endtask

    task test_fetch;
        ack_mode = 1'b1; rdata_val = 32'h00A00313;
        inst_rd_en = 1'b1; inst_addr = 32'h100;
        step();
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            bad++; $display("FAIL fetch_req: req %b we %b be %b addr %h want 1 0 1111 00000100",
                mem_req, mem_we, mem_be, mem_addr);
        end
        step();
        total++;
        if ({inst_ready, mem_req} !== 2'b10 || inst_data !== 32'h00A00313) begin
            bad++; $display("FAIL fetch_ready: ready %b req %b data %h want 1 0 00a00313",
                inst_ready, mem_req, inst_data);
        end
        inst_rd_en = 1'b0;
        step();
        total++;
        if (inst_ready !== 1'b0 || state_dbg !== IDLE) begin
            bad++; $display("FAIL fetch_pulse: ready %b state %0d want 0 0", inst_ready, state_dbg);
        end
    endtask

    task test_timeout;
        int n;
        ack_mode = 1'b0;
        inst_rd_en = 1'b1; inst_addr = 32'h200;
        step();
        n = 0;
        while (mem_req && n < 10) begin
            n++;
            step();
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 4", n); end
        total++;
        if ({bus_err, inst_ready} !== 2'b11 || inst_data !== 32'h0) begin
            bad++; $display("FAIL timeout_err: bus_err %b ready %b data %h want 1 1 00000000",
                bus_err, inst_ready, inst_data);
        end
        inst_rd_en = 1'b0;
        step();
        total++;
        if ({bus_err, inst_ready} !== 2'b00) begin
            bad++; $display("FAIL timeout_pulse: got %b want 00", {bus_err, inst_ready});
        end
    endtask

    task test_store;
        bit seen;
        ack_mode = 1'b0;
        data_wr_en_ma = 1'b1; data_addr = 32'h23; data_wr = 32'hAB; data_rd_wr_ctrl = 2'b00;
        step();
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1000, 32'h20, 32'hABABABAB}) begin
            bad++; $display("FAIL store_byte: req %b we %b be %b addr %h wdata %h want 1 1 1000 00000020 abababab",
                mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        step();
        total++;
        if ({mem_req, mem_be, mem_addr, mem_wdata, data_ready} !== {1'b1, 4'b1000, 32'h20, 32'hABABABAB, 1'b0}) begin
            bad++; $display("FAIL store_hold: req %b be %b addr %h wdata %h ready %b want held",
                mem_req, mem_be, mem_addr, mem_wdata, data_ready);
        end
        ack_mode = 1'b1;
        wait_ready(1'b1, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL store_ready: seen 0 want 1"); end
        data_wr_en_ma = 1'b0;
        step();
        // Load and store enables together mean a store.
        data_rd_en_ma = 1'b1; data_wr_en_ma = 1'b1;
        data_addr = 32'h22; data_wr = 32'h5678_1234; data_rd_wr_ctrl = 2'b01;
        step();
        total++;
        if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b1100, 32'h12341234}) begin
            bad++; $display("FAIL store_half: we %b be %b wdata %h want 1 1100 12341234",
                mem_we, mem_be, mem_wdata);
        end
        wait_ready(1'b1, seen);
        idle_inputs();
        step();
    endtask

    task test_load;
        bit seen;
        ack_mode = 1'b1; rdata_val = 32'hBEEF1234;
        for (int i = 0; i < 5; i++) begin
            data_rd_en_ma = 1'b1; data_addr = ld_addr[i]; data_rd_wr_ctrl = ld_size[i];
            step();
            total++;
            if ({mem_we, mem_be, mem_addr} !== {1'b0, ld_be[i], ld_addr[i] & 32'hFFFF_FFFC}) begin
                bad++; $display("FAIL load_req[%0d]: we %b be %b addr %h want 0 %b %h",
                    i, mem_we, mem_be, mem_addr, ld_be[i], ld_addr[i] & 32'hFFFF_FFFC);
            end
            wait_ready(1'b1, seen);
            total++;
            if (!seen || data_rd !== ld_exp[i]) begin
                bad++; $display("FAIL load_data[%0d]: seen %0b got %h want %h", i, seen, data_rd, ld_exp[i]);
            end
            data_rd_en_ma = 1'b0;
            step();
        end
    endtask

    task test_misalign;
        ack_mode = 1'b1;
        obs_q.delete();
        data_rd_en_ma = 1'b1; data_addr = 32'h22; data_rd_wr_ctrl = 2'b10;
        step();
        total++;
        if ({data_ready, misalign_err, mem_req} !== 3'b110 || data_rd !== 32'h0) begin
            bad++; $display("FAIL misalign_word: rdy/err/req %b data %h want 110 00000000",
                {data_ready, misalign_err, mem_req}, data_rd);
        end
        data_rd_en_ma = 1'b0;
        step();
        total++;
        if (misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_pulse: got 1 want 0"); end
        data_rd_en_ma = 1'b1; data_addr = 32'h21; data_rd_wr_ctrl = 2'b01;
        step();
        total++;
        if ({data_ready, misalign_err, mem_req} !== 3'b110) begin
            bad++; $display("FAIL misalign_half: got %b want 110", {data_ready, misalign_err, mem_req});
        end
        data_rd_en_ma = 1'b0;
        step();
        inst_rd_en = 1'b1; inst_addr = 32'h102;
        step();
        total++;
        if ({inst_ready, misalign_err, mem_req} !== 3'b110 || inst_data !== 32'h0) begin
            bad++; $display("FAIL misalign_fetch: rdy/err/req %b data %h want 110 00000000",
                {inst_ready, misalign_err, mem_req}, inst_data);
        end
        inst_rd_en = 1'b0;
        step();
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL misalign_no_access: got %0d accesses want 0", obs_q.size());
        end
    endtask

    task test_clk_en;
        ack_mode = 1'b0; rdata_val = 32'hCAFEF00D;
        inst_rd_en = 1'b1; inst_addr = 32'h300;
        step();
        clk_en = 1'b0; ack_mode = 1'b1;
        repeat (6) step();
        total++;
        if ({mem_req, inst_ready, bus_err} !== 3'b100 || state_dbg !== INST_WAIT) begin
            bad++; $display("FAIL clken_freeze: req/rdy/err %b state %0d want 100 %0d",
                {mem_req, inst_ready, bus_err}, state_dbg, INST_WAIT);
        end
        clk_en = 1'b1;
        step();
        total++;
        if (inst_ready !== 1'b1 || inst_data !== 32'hCAFEF00D) begin
            bad++; $display("FAIL clken_resume: ready %b data %h want 1 cafef00d", inst_ready, inst_data);
        end
        clk_en = 1'b0; inst_rd_en = 1'b0;
        repeat (2) step();
        total++;
        if (inst_ready !== 1'b1) begin bad++; $display("FAIL clken_pulse_hold: got 0 want 1"); end
        clk_en = 1'b1;
        step();
        total++;
        if (inst_ready !== 1'b0) begin bad++; $display("FAIL clken_pulse_end: got 1 want 0"); end
    endtask

    task test_reset_midflight;
        int late;
        ack_mode = 1'b0;
        data_rd_en_ma = 1'b1; data_addr = 32'h40; data_rd_wr_ctrl = 2'b10;
        step(); step();
        total++;
        if (state_dbg !== DATA_WAIT || mem_req !== 1'b1) begin
            bad++; $display("FAIL midflight_setup: state %0d req %b want %0d 1", state_dbg, mem_req, DATA_WAIT);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_we, data_ready, inst_ready, bus_err, misalign_err, mem_addr, mem_be,
             mem_wdata, inst_data, data_rd} !== '0 || state_dbg !== IDLE) begin
            bad++; $display("FAIL midflight_reset: req %b addr %h inst %h data %h state %0d want 0",
                mem_req, mem_addr, inst_data, data_rd, state_dbg);
        end
        data_rd_en_ma = 1'b0; ack_force = 1'b1;
        step();
        rst_n = 1'b1;
        late = 0;
        repeat (5) begin
            step();
            if (data_ready || inst_ready || mem_req) late++;
        end
        ack_force = 1'b0;
        total++;
        if (late != 0) begin bad++; $display("FAIL midflight_late_ack: got %0d active cycles want 0", late); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_fetch();
        test_timeout();
        test_store();
        test_load();
        test_misalign();
        test_clk_en();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
